ex_muldiv_unit: RTL and testbench

- Parametrised multi-cycle execute unit for the RV32M/RV64M extension.
- Sits beside the single-cycle ALU in the execute stage and is launched by the decoded op with its source operands.
- Multiply is a fixed-latency pipeline; divide/remainder is an iterative radix-2 restoring divider.
- Holds the pipeline through stallreq until the result is returned together with its writeback address.

---
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div unit.
interface ex_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] opv1;
    logic [XLEN-1:0] opv2;
    logic [4:0]      reg_waddr_i;
    logic            we_i;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic [4:0]      reg_waddr_o;
    logic            we_o;
    logic            busy;
    logic            stallreq;

    modport master (
        output flush, start, op, opv1, opv2, reg_waddr_i, we_i,
        input  result, result_valid, reg_waddr_o, we_o, busy, stallreq
    );

    modport slave (
        input  flush, start, op, opv1, opv2, reg_waddr_i, we_i,
        output result, result_valid, reg_waddr_o, we_o, busy, stallreq
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M execute unit: fixed-latency multiply and radix-2 restoring divide,
// one operation in flight, result returned with its writeback address.
module ex_muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave mdu
);
    localparam int unsigned CntW = $clog2(XLEN + MUL_STAGES + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [4:0]      waddr_q, waddr_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            result_valid_q, result_valid_d;
    logic [4:0]      reg_waddr_q, reg_waddr_d;
    logic            we_o_q, we_o_d;

    // Multiplier reads the live inputs in IDLE so MUL_STAGES=1 can finish on accept.
    logic [2:0]             mul_op;
    logic [XLEN-1:0]        mul_a, mul_b, mul_res;
    logic signed [2*XLEN+1:0] mul_ext_a, mul_ext_b, mul_prod;

    always_comb begin
        mul_op    = (state_q == StIdle) ? mdu.op   : op_q;
        mul_a     = (state_q == StIdle) ? mdu.opv1 : op1_q;
        mul_b     = (state_q == StIdle) ? mdu.opv2 : op2_q;
        mul_ext_a = {{(XLEN+2){((mul_op == 3'd1) || (mul_op == 3'd2)) & mul_a[XLEN-1]}}, mul_a};
        mul_ext_b = {{(XLEN+2){(mul_op == 3'd1) & mul_b[XLEN-1]}}, mul_b};
        mul_prod  = mul_ext_a * mul_ext_b;
        mul_res   = (mul_op == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    logic            div_signed, in_neg1, in_neg2, div_zero, div_ovf;
    logic [XLEN-1:0] abs1, abs2, special_res, min_neg;

    always_comb begin
        min_neg     = {1'b1, {(XLEN-1){1'b0}}};
        div_signed  = ~mdu.op[0];
        in_neg1     = div_signed & mdu.opv1[XLEN-1];
        in_neg2     = div_signed & mdu.opv2[XLEN-1];
        abs1        = in_neg1 ? -mdu.opv1 : mdu.opv1;
        abs2        = in_neg2 ? -mdu.opv2 : mdu.opv2;
        div_zero    = (mdu.opv2 == '0);
        div_ovf     = div_signed & (mdu.opv1 == min_neg) & (mdu.opv2 == '1);
        if (mdu.op[1]) special_res = div_zero ? mdu.opv1 : '0;
        else           special_res = div_zero ? '1 : mdu.opv1;
    end

    // op1_q doubles as the dividend/quotient shift register during DIV.
    logic [XLEN:0]   rem_shift, rem_diff;
    logic            step_ok;
    logic [XLEN-1:0] rem_next, quot_next, quot_fix, rem_fix, div_res;

    always_comb begin
        rem_shift = {rem_q, op1_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, op2_q};
        step_ok   = ~rem_diff[XLEN];
        rem_next  = step_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_next = {op1_q[XLEN-2:0], step_ok};
        quot_fix  = neg_quot_q ? -quot_next : quot_next;
        rem_fix   = neg_rem_q ? -rem_next : rem_next;
        div_res   = op_q[1] ? rem_fix : quot_fix;
    end

    logic            done_go, done_we;
    logic [XLEN-1:0] done_res;
    logic [4:0]      done_waddr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rem_d       = rem_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        waddr_d     = waddr_q;
        we_d        = we_q;
        done_go     = 1'b0;
        done_res    = mul_res;
        done_waddr  = waddr_q;
        done_we     = we_q;

        unique case (state_q)
            StIdle: begin
                if (mdu.start) begin
                    op_d       = mdu.op;
                    waddr_d    = mdu.reg_waddr_i;
                    we_d       = mdu.we_i;
                    done_waddr = mdu.reg_waddr_i;
                    done_we    = mdu.we_i;
                    if (!mdu.op[2]) begin
                        op1_d = mdu.opv1;
                        op2_d = mdu.opv2;
                        cnt_d = CntW'(MUL_STAGES - 1);
                        if (MUL_STAGES == 1) done_go = 1'b1;
                        else                 state_d = StMul;
                    end else if (div_zero || div_ovf) begin
                        done_go  = 1'b1;
                        done_res = special_res;
                    end else begin
                        state_d    = StDiv;
                        op1_d      = abs1;
                        op2_d      = abs2;
                        rem_d      = '0;
                        cnt_d      = CntW'(XLEN);
                        neg_quot_d = in_neg1 ^ in_neg2;
                        neg_rem_d  = in_neg1;
                    end
                end
            end
            StMul: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) done_go = 1'b1;
            end
            StDiv: begin
                op1_d = quot_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    done_go  = 1'b1;
                    done_res = div_res;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (done_go) state_d = StDone;
        result_valid_d = done_go;
        result_d       = done_go ? done_res   : result_q;
        reg_waddr_d    = done_go ? done_waddr : reg_waddr_q;
        we_o_d         = done_go ? done_we    : we_o_q;

        // Flush also blocks a same-cycle accept, so outputs keep their old values.
        if (mdu.flush) begin
            state_d        = StIdle;
            result_valid_d = 1'b0;
            result_d       = result_q;
            reg_waddr_d    = reg_waddr_q;
            we_o_d         = we_o_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            op_q           <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            rem_q          <= '0;
            neg_quot_q     <= 1'b0;
            neg_rem_q      <= 1'b0;
            waddr_q        <= '0;
            we_q           <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            reg_waddr_q    <= '0;
            we_o_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            rem_q          <= rem_d;
            neg_quot_q     <= neg_quot_d;
            neg_rem_q      <= neg_rem_d;
            waddr_q        <= waddr_d;
            we_q           <= we_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            reg_waddr_q    <= reg_waddr_d;
            we_o_q         <= we_o_d;
        end
    end

    assign mdu.result       = result_q;
    assign mdu.result_valid = result_valid_q;
    assign mdu.reg_waddr_o  = reg_waddr_q;
    assign mdu.we_o         = we_o_q;
    assign mdu.busy         = (state_q != StIdle);
    assign mdu.stallreq     = mdu.start & ~result_valid_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: XLEN=32/MUL_STAGES=2 and XLEN=64/MUL_STAGES=1 instances.
module tb_ex_muldiv_unit;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  waddr;
        logic        we;
        int          acc;
        int          due;
    } exp_t;

    typedef struct {
        int sel;
        bit full;
    } ic_t;

    exp_t q0[$];
    exp_t q1[$];
    ic_t  icq[$];

    ex_muldiv_if #(.XLEN(32)) if32 ();
    ex_muldiv_if #(.XLEN(64)) if64 ();

    ex_muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) u_dut32 (.clk(clk), .rst(rst), .mdu(if32));
    ex_muldiv_unit #(.XLEN(64), .MUL_STAGES(1)) u_dut64 (.clk(clk), .rst(rst), .mdu(if64));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-precision signed/unsigned arithmetic on 128-bit values.
    function automatic logic [63:0] model(input int xl, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, am, bm, minv;
        logic signed [127:0] sa, sb, ua, ub, p;
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
        minv = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        am = a & mask;
        bm = b & mask;
        ua = {64'b0, am};
        ub = {64'b0, bm};
        sa = (xl == 32) ? {{96{am[31]}}, am[31:0]} : {{64{am[63]}}, am};
        sb = (xl == 32) ? {{96{bm[31]}}, bm[31:0]} : {{64{bm[63]}}, bm};
        case (op)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >> xl;
            3'd2: p = (sa * ub) >> xl;
            3'd3: p = (ua * ub) >> xl;
            3'd4: begin
                if (bm == 0)                          p = {64'b0, mask};
                else if (am == minv && bm == mask)    p = {64'b0, am};
                else                                  p = sa / sb;
            end
            3'd5: p = (bm == 0) ? {64'b0, mask} : ua / ub;
            3'd6: begin
                if (bm == 0)                          p = {64'b0, am};
                else if (am == minv && bm == mask)    p = '0;
                else                                  p = sa % sb;
            end
            default: p = (bm == 0) ? {64'b0, am} : ua % ub;
        endcase
        return p[63:0] & mask;
    endfunction

    function automatic int lat(input int sel, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, minv;
        int xl;
        xl   = (sel == 0) ? 32 : 64;
        mask = (sel == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
        minv = (sel == 0) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        if (!op[2]) return (sel == 0) ? 2 : 1;
        if ((b & mask) == 0) return 1;
        if (!op[0] && (a & mask) == minv && (b & mask) == mask) return 1;
        return xl + 1;
    endfunction

    task automatic set_if(input int sel, input logic st, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] wa, input logic we);
        if (sel == 0) begin
            if32.start = st; if32.op = op; if32.opv1 = a[31:0]; if32.opv2 = b[31:0];
            if32.reg_waddr_i = wa; if32.we_i = we;
        end else begin
            if64.start = st; if64.op = op; if64.opv1 = a; if64.opv2 = b;
            if64.reg_waddr_i = wa; if64.we_i = we;
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) if32.start = v; else if64.start = v;
    endtask

    task automatic set_flush(input int sel, input logic v);
        if (sel == 0) if32.flush = v; else if64.flush = v;
    endtask

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? if32.result_valid : if64.result_valid;
    endfunction

    task automatic idle(input int sel, input int n);
        set_start(sel, 1'b0);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called right after a rising edge with the DUT idle; returns after the result cycle.
    task automatic issue(input int sel, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
        exp_t e;
        logic [4:0] wa;
        logic we;
        wa      = 5'($urandom);
        we      = 1'($urandom);
        e.res   = model((sel == 0) ? 32 : 64, op, a, b);
        e.waddr = wa;
        e.we    = we;
        e.acc   = cyc + 1;
        e.due   = cyc + lat(sel, op, a, b);
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        set_if(sel, 1'b1, op, a, b, wa, we);
        @(posedge clk); #1;
        set_if(sel, 1'b1, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               5'($urandom), 1'($urandom));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (get_valid(sel)) break;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] pick(input int sel);
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0: return 64'd0;
            1: return '1;
            2: return (sel == 0) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic directed(input int sel);
        logic [63:0] minv, ones;
        minv = (sel == 0) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        ones = (sel == 0) ? 64'hFFFF_FFFF : '1;
        issue(sel, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(sel, 3'd1, minv, minv);
        issue(sel, 3'd3, ones, ones);
        issue(sel, 3'd2, ones, 64'd2);
        issue(sel, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        issue(sel, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        issue(sel, 3'd5, 64'd100, 64'd7);
        issue(sel, 3'd0, 64'd123, 64'd456);  // back-to-back after DIVU, start held
        issue(sel, 3'd7, 64'd100, 64'd7);
        issue(sel, 3'd4, 64'd1234, 64'd0);
        issue(sel, 3'd7, 64'd5, 64'd0);
        issue(sel, 3'd4, minv, ones);
        issue(sel, 3'd6, minv, ones);
        idle(sel, 1);
    endtask

    task automatic flush_test(input int sel);
        ic_t c;
        set_if(sel, 1'b1, 3'd4, 64'd1000000, 64'd3, 5'd9, 1'b1);
        repeat (10) begin @(posedge clk); #1; end
        set_start(sel, 1'b0);
        set_flush(sel, 1'b1);
        @(posedge clk); #1;
        set_flush(sel, 1'b0);
        c.sel = sel; c.full = 1'b0;
        icq.push_back(c);
        issue(sel, 3'd0, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic reset_test(input int sel);
        ic_t c;
        set_if(sel, 1'b1, 3'd5, 64'd99999, 64'd7, 5'd17, 1'b1);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_start(sel, 1'b0);
        c.sel = sel; c.full = 1'b1;
        icq.push_back(c);
    endtask

    initial begin
        ic_t c;
        rst = 1'b1;
        set_if(0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        set_if(1, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        set_flush(0, 1'b0);
        set_flush(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            c.sel = s; c.full = 1'b1;
            icq.push_back(c);
        end
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            directed(s);
            flush_test(s);
            idle(s, 2);
            reset_test(s);
            idle(s, 1);
            for (int i = 0; i < 30; i++) begin
                issue(s, 3'($urandom_range(0, 7)), pick(s), pick(s));
                if ($urandom_range(0, 2) == 0) idle(s, $urandom_range(1, 3));
            end
            idle(s, 2);
        end
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int sel);
        logic v, st, sr, bz, we;
        logic [63:0] res;
        logic [4:0] wa;
        exp_t e;
        bit have;
        if (sel == 0) begin
            v = if32.result_valid; st = if32.start; sr = if32.stallreq; bz = if32.busy;
            res = {32'b0, if32.result}; wa = if32.reg_waddr_o; we = if32.we_o;
            have = (q0.size() > 0);
            if (have) e = q0[0];
        end else begin
            v = if64.result_valid; st = if64.start; sr = if64.stallreq; bz = if64.busy;
            res = if64.result; wa = if64.reg_waddr_o; we = if64.we_o;
            have = (q1.size() > 0);
            if (have) e = q1[0];
        end
        check($sformatf("stallreq[%0d]", sel), 64'(sr), 64'(st & ~v));
        if (have) check($sformatf("busy[%0d]", sel), 64'(bz), 64'(cyc >= e.acc));
        if (v) begin
            if (!have) begin
                check($sformatf("unexpected_valid[%0d]", sel), 64'(v), 64'd0);
            end else begin
                if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check($sformatf("result[%0d]", sel), res, e.res);
                check($sformatf("reg_waddr_o[%0d]", sel), 64'(wa), 64'(e.waddr));
                check($sformatf("we_o[%0d]", sel), 64'(we), 64'(e.we));
                check($sformatf("latency_cycle[%0d]", sel), 64'(cyc), 64'(e.due));
            end
        end else if (have && cyc > e.due) begin
            check($sformatf("missing_result[%0d]", sel), 64'(v), 64'd1);
            if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    task automatic idle_check(input ic_t c);
        logic v, bz, we;
        logic [63:0] res;
        logic [4:0] wa;
        if (c.sel == 0) begin
            v = if32.result_valid; bz = if32.busy; res = {32'b0, if32.result};
            wa = if32.reg_waddr_o; we = if32.we_o;
        end else begin
            v = if64.result_valid; bz = if64.busy; res = if64.result;
            wa = if64.reg_waddr_o; we = if64.we_o;
        end
        check($sformatf("idle_busy[%0d]", c.sel), 64'(bz), 64'd0);
        check($sformatf("idle_valid[%0d]", c.sel), 64'(v), 64'd0);
        if (c.full) begin
            check($sformatf("rst_result[%0d]", c.sel), res, 64'd0);
            check($sformatf("rst_waddr[%0d]", c.sel), 64'(wa), 64'd0);
            check($sformatf("rst_we[%0d]", c.sel), 64'(we), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (icq.size() > 0) idle_check(icq.pop_front());
            mon(0);
            mon(1);
        end
        if (done) begin
            check("drain_q32", 64'(q0.size()), 64'd0);
            check("drain_q64", 64'(q1.size()), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end
endmodule
